arp_reply_tx: RTL
=================

// Module: arp_reply_tx
// PURPOSE
//  Downstream of the ARP receive parser: on each validated ARP request, serialises a
//  28-byte ARP reply payload (optionally zero-padded to 46 bytes) as an 8-bit
//  valid/ready byte stream.
//  The stream goes to the Ethernet TX header inserter, which prepends DA/SA/EtherType 0x0806.
//  ARP responses received (arp_oper=1) produce no transmission.
// PARAMETERS
//  PAD_EN   1   1: append 18 zero bytes (frame payload 46 B); 0: payload ends at byte 27
// PORTS
//  aclk            in   1   clock; single clock domain
//  aresetn         in   1   asynchronous active-low reset
//  arp_data_valid  in   1   1-cycle pulse: received ARP packet passed all checks
//  arp_oper        in   1   opcode of received packet: 0=request, 1=response; valid with pulse
//  mac_s_addr      in   48  requester MAC (sender HW addr of received packet); valid with pulse
//  ip_s_addr       in   32  peer IP address (configuration)
//  mac_d_addr      in   48  local MAC address (configuration)
//  ip_d_addr       in   32  local IP address (configuration)
//  m_tdata         out  8   reply byte
//  m_tvalid        out  1   m_tdata valid
//  m_tready        in   1   downstream accepts byte when m_tvalid&&m_tready
//  m_tlast         out  1   high with final byte of payload
//  busy            out  1   frame in progress or pending
//  drop            out  1   1-cycle pulse: trigger lost (pending slot already full)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, m_tvalid=0, m_tlast=0, m_tdata=0,
//   busy=0, drop=0, pending=0, byte counter=0. Reset mid-frame aborts; no resume.
//  Trigger = arp_data_valid && !arp_oper; arp_data_valid with arp_oper=1 ignored.
//  On trigger, snapshot mac_s_addr, mac_d_addr, ip_d_addr, ip_s_addr into frame regs.
//  Byte order (MSB first per field), idx 0..27:
//   0-1 0x0001 | 2-3 0x0800 | 4 0x06 | 5 0x04 | 6-7 0x0002 (OPER reply)
//   8-13 SHA=local MAC | 14-17 SPA=local IP | 18-23 THA=requester MAC | 24-27 TPA=peer IP
//   PAD_EN=1: idx 28..45 = 0x00; last idx = 45, else 27.
//  FSM:
//   IDLE: if trigger or pending -> load snapshot (pending source takes its stored
//         snapshot), idx=0, -> SEND; m_tvalid rises the cycle after trigger.
//   SEND: m_tvalid=1; idx advances only on m_tvalid&&m_tready; m_tdata/m_tlast held
//         stable while m_tvalid&&!m_tready. On accept of last idx -> IDLE, m_tvalid=0.
//  Latency: trigger at cycle N -> byte 0 presented at N+1 (if IDLE, no pending).
//  Back-to-back: at least one m_tvalid=0 cycle between frames (IDLE pass).
//  Pending: a trigger while not IDLE (or same cycle as IDLE pops pending) stores its
//   snapshot in a 1-deep slot; if slot full, new trigger dropped, drop pulses 1 cycle,
//   frame in flight and pending snapshot unchanged.
//  Trigger in the cycle the last byte is accepted: goes to pending slot (not dropped
//   unless slot full).
//  busy = (state!=IDLE) || pending.
//  Counter 6 bits; never wraps (cleared on load).
//  Config inputs changing mid-frame do not affect the frame in flight.
// TESTING
//  1 Request, local MAC 02:00:00:00:00:01, IP 192.168.1.10, requester MAC
//    aa:bb:cc:dd:ee:ff, peer IP 192.168.1.20, m_tready=1, PAD_EN=1 -> 46 bytes
//    00 01 08 00 06 04 00 02 02..01 c0 a8 01 0a aa..ff c0 a8 01 14 + 18x00,
//    tlast on byte 45, byte0 one cycle after pulse.
//  2 Same with PAD_EN=0 -> 28 bytes, tlast on byte 27 (0x14).
//  3 Random m_tready stalls (~50%) -> identical byte sequence; tdata/tlast stable while stalled.
//  4 arp_data_valid with arp_oper=1 -> m_tvalid stays 0, busy stays 0.
//  5 Three triggers during frame 1 (requesters ...:01, ...:02, ...:03) -> frame 2 uses
//    ...:02, third trigger pulses drop once; >=1 idle cycle between frames.
//  6 aresetn low at byte 10 -> m_tvalid=0 immediately, busy=0; next trigger
//    restarts at byte 0.

Source files
------------

// File: rtl/arp_reply_tx_if.sv
// Byte-stream link from the ARP reply serialiser to the Ethernet TX header inserter.
// The producer drives data, valid and last. The consumer drives ready.
interface arp_reply_tx_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/arp_reply_tx.sv
// Serialises a 28-byte ARP reply, optionally zero-padded to 46 bytes, for each validated
// ARP request. A 1-deep pending slot holds one request that arrives while a reply is
// still being sent.
module arp_reply_tx #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 arp_data_valid,
    input  logic                 arp_oper,
    input  logic [47:0]          mac_s_addr,
    input  logic [31:0]          ip_s_addr,
    input  logic [47:0]          mac_d_addr,
    input  logic [31:0]          ip_d_addr,
    arp_reply_tx_if.master       m,
    output logic                 busy,
    output logic                 drop
);

    localparam logic [5:0] LAST = PAD_EN ? 6'd45 : 6'd27;

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state;
    logic [5:0]   idx;
    logic [7:0]   tdata_r;
    logic         tvalid_r;
    logic         tlast_r;
    logic         drop_r;
    logic         pend_vld;
    logic [159:0] frame;
    logic [159:0] pend;
    logic [159:0] snap_in;

    logic trig, accept, load_pend, load_new, store_pend, drop_now;

    // Snapshot layout follows payload order: SHA, SPA, THA, TPA.
    assign snap_in = {mac_d_addr, ip_d_addr, mac_s_addr, ip_s_addr};

    assign trig       = arp_data_valid & ~arp_oper;
    assign accept     = tvalid_r & m.m_tready;
    assign load_pend  = (state == IDLE) & pend_vld;
    assign load_new   = (state == IDLE) & ~pend_vld & trig;
    assign store_pend = trig & (((state == IDLE) & pend_vld) | ((state == SEND) & ~pend_vld));
    assign drop_now   = trig & (state == SEND) & pend_vld;

    function automatic logic [7:0] byte_at(input logic [159:0] f, input logic [5:0] i);
        logic [159:0] sh;
        logic [7:0]   b;
        sh = f << {i - 6'd8, 3'b000};
        case (i)
            6'd0, 6'd3, 6'd6: b = 8'h00;
            6'd1:             b = 8'h01;
            6'd2:             b = 8'h08;
            6'd4:             b = 8'h06;
            6'd5:             b = 8'h04;
            6'd7:             b = 8'h02;
            default:          b = (i < 6'd28) ? sh[159:152] : 8'h00;
        endcase
        return b;
    endfunction

    // Frame and pending snapshots are pure data and need no reset.
    always_ff @(posedge aclk) begin
        if (load_pend) begin
            frame <= pend;
        end else if (load_new) begin
            frame <= snap_in;
        end
        if (store_pend) begin
            pend <= snap_in;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            idx      <= 6'd0;
            tdata_r  <= 8'h00;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            drop_r   <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            drop_r <= drop_now;
            if (store_pend) begin
                pend_vld <= 1'b1;
            end else if (load_pend) begin
                pend_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load_pend || load_new) begin
                        state    <= SEND;
                        idx      <= 6'd0;
                        tdata_r  <= 8'h00;
                        tvalid_r <= 1'b1;
                        tlast_r  <= 1'b0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (tlast_r) begin
                            state    <= IDLE;
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            tdata_r  <= 8'h00;
                        end else begin
                            idx     <= idx + 6'd1;
                            tdata_r <= byte_at(frame, idx + 6'd1);
                            tlast_r <= ((idx + 6'd1) == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m.m_tdata  = tdata_r;
    assign m.m_tvalid = tvalid_r;
    assign m.m_tlast  = tlast_r;
    assign busy       = (state != IDLE) | pend_vld;
    assign drop       = drop_r;

endmodule
